// File: rtl/load_data_unit_if.sv
// Load-unit instruction IDs and the bus bundle between the MEM stage,
// the load unit and the data-memory port.

package instr_pkg;
  // Load instruction IDs shared by the decoder, the load unit and the bench.
  localparam logic [5:0] INSTR_LB  = 6'd10;
  localparam logic [5:0] INSTR_LH  = 6'd11;
  localparam logic [5:0] INSTR_LW  = 6'd12;
  localparam logic [5:0] INSTR_LBU = 6'd13;
  localparam logic [5:0] INSTR_LHU = 6'd14;
endpackage

interface load_data_unit_if;
  // MEM-stage request side
  logic        req_valid_in;
  logic [5:0]  instr_id_in;
  logic [31:0] addr_in;
  logic [4:0]  rd_addr_in;
  logic        req_ready_out;
  logic        stall_out;
  // Data-memory bus side
  logic        mem_rd_req_out;
  logic [31:0] mem_addr_out;
  logic        mem_rd_gnt_in;
  logic        mem_rvalid_in;
  logic [31:0] mem_rdata_in;
  // Writeback result side
  logic        load_valid_out;
  logic [4:0]  load_rd_addr_out;
  logic [31:0] load_data_out;
  logic        misaligned_out;

  // The load unit itself
  modport slave (
    input  req_valid_in, instr_id_in, addr_in, rd_addr_in,
    input  mem_rd_gnt_in, mem_rvalid_in, mem_rdata_in,
    output req_ready_out, stall_out, mem_rd_req_out, mem_addr_out,
    output load_valid_out, load_rd_addr_out, load_data_out, misaligned_out
  );

  // The pipeline/memory environment driving the load unit
  modport master (
    output req_valid_in, instr_id_in, addr_in, rd_addr_in,
    output mem_rd_gnt_in, mem_rvalid_in, mem_rdata_in,
    input  req_ready_out, stall_out, mem_rd_req_out, mem_addr_out,
    input  load_valid_out, load_rd_addr_out, load_data_out, misaligned_out
  );
endinterface

// File: rtl/load_data_unit.sv
// Load engine: accepts one load at a time, issues a word-aligned bus read,
// then extracts and sign/zero-extends the addressed byte, halfword or word.

module load_data_unit
  import instr_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  load_data_unit_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t      state_q;
  logic [5:0]  id_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;
  logic        ready_q;
  logic        mem_req_q;
  logic [31:0] mem_addr_q;
  logic        load_valid_q;
  logic [4:0]  load_rd_q;
  logic [31:0] load_data_q;
  logic        misaligned_q;

  logic        is_load;
  logic        accept;
  logic        misaligned_d;
  logic [31:0] load_data_d;

  // Byte/halfword/word selection and extension from the fetched word.
  function automatic logic [31:0] extract_load(input logic [5:0]  id,
                                               input logic [1:0]  off,
                                               input logic [31:0] rdata);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res;
    case (off)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
    half_v = off[1] ? rdata[31:16] : rdata[15:0];
    case (id)
      INSTR_LB:  res = {{24{byte_v[7]}}, byte_v};
      INSTR_LBU: res = {24'd0, byte_v};
      INSTR_LH:  res = {{16{half_v[15]}}, half_v};
      INSTR_LHU: res = {16'd0, half_v};
      INSTR_LW:  res = rdata;
      default:   res = 32'd0;
    endcase
    return res;
  endfunction

  // Accept decode, alignment check and result extraction.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
    is_load      = 1'b0;
    misaligned_d = 1'b0;
    case (bus.instr_id_in)
      INSTR_LB, INSTR_LBU: is_load = 1'b1;
      INSTR_LH, INSTR_LHU: begin
        is_load      = 1'b1;
        misaligned_d = bus.addr_in[0];
      end
      INSTR_LW: begin
        is_load      = 1'b1;
        misaligned_d = (bus.addr_in[1:0] != 2'b00);
      end
      default: ;
    endcase
    accept      = (state_q == S_IDLE) && bus.req_valid_in && is_load;
    load_data_d = extract_load(id_q, off_q, bus.mem_rdata_in);
  end

  // Control FSM with registered outputs and the latched load context.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      id_q         <= '0;
      off_q        <= '0;
      rd_q         <= '0;
      ready_q      <= 1'b1;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      load_valid_q <= 1'b0;
      load_rd_q    <= '0;
      load_data_q  <= '0;
      misaligned_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      load_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            id_q    <= bus.instr_id_in;
            off_q   <= bus.addr_in[1:0];
            rd_q    <= bus.rd_addr_in;
            ready_q <= 1'b0;
            if (misaligned_d) begin
              misaligned_q <= 1'b1;
              state_q      <= S_DONE;
            end else begin
              mem_req_q  <= 1'b1;
              mem_addr_q <= {bus.addr_in[31:2], 2'b00};
              state_q    <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (bus.mem_rd_gnt_in) begin
            mem_req_q <= 1'b0;
            if (bus.mem_rvalid_in) begin
              load_data_q  <= load_data_d;
              load_rd_q    <= rd_q;
              load_valid_q <= 1'b1;
              state_q      <= S_DONE;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (bus.mem_rvalid_in) begin
            load_data_q  <= load_data_d;
            load_rd_q    <= rd_q;
            load_valid_q <= 1'b1;
            state_q      <= S_DONE;
          end
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Stall covers the accept cycle of an aligned load and the whole bus wait;
  // it drops in DONE so the load advances to WB together with its data.
  assign bus.stall_out = (state_q == S_REQ) || (state_q == S_WAIT) ||
                         (accept && !misaligned_d);

  assign bus.req_ready_out    = ready_q;
  assign bus.mem_rd_req_out   = mem_req_q;
  assign bus.mem_addr_out     = mem_addr_q;
  assign bus.load_valid_out   = load_valid_q;
  assign bus.load_rd_addr_out = load_rd_q;
  assign bus.load_data_out    = load_data_q;
  assign bus.misaligned_out   = misaligned_q;

endmodule

// File: tb/tb_load_data_unit.sv
// Directed bench for load_data_unit: table of single-load vectors plus
// hand-written sequences for delayed handshakes and reset mid-flight.

module tb_load_data_unit;
  import instr_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  load_data_unit_if bus();

  load_data_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [5:0]  id;
    logic [31:0] addr;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        exp_mis;
    logic [31:0] exp_maddr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.req_valid_in  = 1'b0;
    bus.instr_id_in   = 6'd0;
    bus.addr_in       = 32'd0;
    bus.rd_addr_in    = 5'd0;
    bus.mem_rd_gnt_in = 1'b0;
    bus.mem_rvalid_in = 1'b0;
    bus.mem_rdata_in  = 32'd0;
  endtask

  // Advance to just after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One load with grant and rvalid together in the first REQ cycle.
  task automatic run_vec(input vec_t v);
    bus.req_valid_in = 1'b1;
    bus.instr_id_in  = v.id;
    bus.addr_in      = v.addr;
    bus.rd_addr_in   = v.rd;
    #1;
    check({v.name, " c0 stall"}, 32'(bus.stall_out), 32'(!v.exp_mis));
    check({v.name, " c0 ready"}, 32'(bus.req_ready_out), 32'd1);
    next_cycle();
    clear_inputs();
    if (!v.exp_mis) begin
      bus.mem_rd_gnt_in = 1'b1;
      bus.mem_rvalid_in = 1'b1;
      bus.mem_rdata_in  = v.rdata;
      #1;
      check({v.name, " c1 req"},   32'(bus.mem_rd_req_out), 32'd1);
      check({v.name, " c1 maddr"}, bus.mem_addr_out, v.exp_maddr);
      check({v.name, " c1 stall"}, 32'(bus.stall_out), 32'd1);
      next_cycle();
      clear_inputs();
      #1;
      check({v.name, " c2 valid"}, 32'(bus.load_valid_out), 32'd1);
      check({v.name, " c2 data"},  bus.load_data_out, v.exp_data);
      check({v.name, " c2 rd"},    32'(bus.load_rd_addr_out), 32'(v.rd));
      check({v.name, " c2 stall"}, 32'(bus.stall_out), 32'd0);
      check({v.name, " c2 ready"}, 32'(bus.req_ready_out), 32'd0);
    end else begin
      #1;
      check({v.name, " c1 mis"},   32'(bus.misaligned_out), 32'd1);
      check({v.name, " c1 req"},   32'(bus.mem_rd_req_out), 32'd0);
      check({v.name, " c1 valid"}, 32'(bus.load_valid_out), 32'd0);
      check({v.name, " c1 stall"}, 32'(bus.stall_out), 32'd0);
    end
    next_cycle();
    #1;
    check({v.name, " idle ready"}, 32'(bus.req_ready_out), 32'd1);
    check({v.name, " idle valid"}, 32'(bus.load_valid_out), 32'd0);
    check({v.name, " idle mis"},   32'(bus.misaligned_out), 32'd0);
    check({v.name, " idle req"},   32'(bus.mem_rd_req_out), 32'd0);
    if (!v.exp_mis)
      check({v.name, " data hold"}, bus.load_data_out, v.exp_data);
  endtask

  initial begin
    int valid_cnt;

    vecs[0] = '{"lw_100",   INSTR_LW,  32'h100, 5'd5,  32'hDEADBEEF, 1'b0, 32'h100, 32'hDEADBEEF};
    vecs[1] = '{"lb_203",   INSTR_LB,  32'h203, 5'd1,  32'h80123456, 1'b0, 32'h200, 32'hFFFFFF80};
    vecs[2] = '{"lbu_203",  INSTR_LBU, 32'h203, 5'd2,  32'h80123456, 1'b0, 32'h200, 32'h00000080};
    vecs[3] = '{"lh_302",   INSTR_LH,  32'h302, 5'd7,  32'h8001ABCD, 1'b0, 32'h300, 32'hFFFF8001};
    vecs[4] = '{"lhu_300",  INSTR_LHU, 32'h300, 5'd8,  32'h8001ABCD, 1'b0, 32'h300, 32'h0000ABCD};
    vecs[5] = '{"lb_201",   INSTR_LB,  32'h201, 5'd30, 32'h80123456, 1'b0, 32'h200, 32'h00000034};
    vecs[6] = '{"lw_102",   INSTR_LW,  32'h102, 5'd4,  32'h0,        1'b1, 32'h0,   32'h0};
    vecs[7] = '{"lh_301",   INSTR_LH,  32'h301, 5'd6,  32'h0,        1'b1, 32'h0,   32'h0};
    vecs[8] = '{"lhu_102",  INSTR_LHU, 32'h102, 5'd9,  32'h7FFF0000, 1'b0, 32'h100, 32'h00007FFF};
    vecs[9] = '{"lbu_003",  INSTR_LBU, 32'h003, 5'd31, 32'hAB000000, 1'b0, 32'h000, 32'h000000AB};

    rst_n = 1'b1;
    clear_inputs();
    #2 rst_n = 1'b0;
    #1;
    check("rst ready", 32'(bus.req_ready_out),    32'd1);
    check("rst stall", 32'(bus.stall_out),        32'd0);
    check("rst req",   32'(bus.mem_rd_req_out),   32'd0);
    check("rst maddr", bus.mem_addr_out,          32'd0);
    check("rst valid", 32'(bus.load_valid_out),   32'd0);
    check("rst rd",    32'(bus.load_rd_addr_out), 32'd0);
    check("rst data",  bus.load_data_out,         32'd0);
    check("rst mis",   32'(bus.misaligned_out),   32'd0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // Non-load ID is ignored.
    bus.req_valid_in = 1'b1;
    bus.instr_id_in  = 6'd0;
    bus.addr_in      = 32'h100;
    #1;
    check("nonload stall", 32'(bus.stall_out), 32'd0);
    next_cycle();
    clear_inputs();
    #1;
    check("nonload ready", 32'(bus.req_ready_out),  32'd1);
    check("nonload req",   32'(bus.mem_rd_req_out), 32'd0);
    next_cycle();

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i]);
      next_cycle();
    end

    // Grant 3 cycles late, rvalid 2 cycles after grant, spurious rvalid before grant.
    valid_cnt = 0;
    bus.req_valid_in = 1'b1;
    bus.instr_id_in  = INSTR_LW;
    bus.addr_in      = 32'h400;
    bus.rd_addr_in   = 5'd9;
    next_cycle();
    clear_inputs();
    for (int cyc = 1; cyc <= 8; cyc++) begin
      bus.mem_rd_gnt_in = (cyc == 4);
      bus.mem_rvalid_in = (cyc == 2) || (cyc == 6);
      bus.mem_rdata_in  = (cyc == 2) ? 32'hBADBAD00 : 32'h12345678;
      #1;
      if (bus.load_valid_out) valid_cnt++;
      if (cyc <= 4) begin
        check($sformatf("dly c%0d req", cyc),   32'(bus.mem_rd_req_out), 32'd1);
        check($sformatf("dly c%0d maddr", cyc), bus.mem_addr_out, 32'h400);
      end
      check($sformatf("dly c%0d stall", cyc), 32'(bus.stall_out), 32'(cyc <= 6));
      check($sformatf("dly c%0d valid", cyc), 32'(bus.load_valid_out), 32'(cyc == 7));
      if (cyc == 7) begin
        check("dly data", bus.load_data_out, 32'h12345678);
        check("dly rd",   32'(bus.load_rd_addr_out), 32'd9);
      end
      next_cycle();
    end
    clear_inputs();
    check("dly pulse count", 32'(valid_cnt), 32'd1);

    // Reset while in WAIT, then a stale response arrives.
    bus.req_valid_in = 1'b1;
    bus.instr_id_in  = INSTR_LW;
    bus.addr_in      = 32'h500;
    bus.rd_addr_in   = 5'd3;
    next_cycle();
    clear_inputs();
    bus.mem_rd_gnt_in = 1'b1;
    next_cycle();
    clear_inputs();
    #1;
    check("wait stall", 32'(bus.stall_out), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid rst ready", 32'(bus.req_ready_out),    32'd1);
    check("mid rst stall", 32'(bus.stall_out),        32'd0);
    check("mid rst req",   32'(bus.mem_rd_req_out),   32'd0);
    check("mid rst maddr", bus.mem_addr_out,          32'd0);
    check("mid rst data",  bus.load_data_out,         32'd0);
    check("mid rst rd",    32'(bus.load_rd_addr_out), 32'd0);
    next_cycle();
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      bus.mem_rvalid_in = 1'b1;
      bus.mem_rdata_in  = 32'hCAFEF00D;
      #1;
      check($sformatf("post rst c%0d valid", cyc), 32'(bus.load_valid_out), 32'd0);
      check($sformatf("post rst c%0d ready", cyc), 32'(bus.req_ready_out),  32'd1);
      check($sformatf("post rst c%0d stall", cyc), 32'(bus.stall_out),      32'd0);
      next_cycle();
    end
    clear_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
